// File: rtl/nnrv_uart_loader.sv
// UART boot loader: receives a word-count-prefixed image and writes it into RAM,
// holding the core in reset until done. Optional trailing XOR checksum: NNRV_LOADER_CKSUM_EN.
module nnrv_uart_loader #(
  parameter int XLEN         = 64,
  parameter int MASK_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_WORDS    = 128
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_uart_rx,
  output logic [XLEN-1:0]       o_ram_wr_addr,
  output logic                  o_ram_wr_en,
  output logic [MASK_WIDTH-1:0] o_ram_wr_mask,
  output logic [XLEN-1:0]       o_ram_wr_data,
  output logic                  o_core_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]      MAX_N     = 16'(MAX_WORDS);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] HDR0  = 3'd0;
  localparam logic [2:0] HDR1  = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;
`ifdef NNRV_LOADER_CKSUM_EN
  localparam logic [2:0] CKSUM = 3'd5;
`endif

  logic             rx_sync_p0;
  logic             rx_sync_p1;
  logic             rx_prev_p2;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_shift;
  logic             byte_vld_p3;
  logic             frame_err_p3;
  logic             start_det;

  logic [2:0]       ld_state;
  logic [15:0]      n_words;
  logic [15:0]      word_idx;
  logic [2:0]       byte_cnt;
  logic [XLEN-9:0]  word_buf;
  logic [15:0]      hdr_n;
  logic             last_word;
  logic             ld_active;

  assign start_det = (rx_state == RX_IDLE) && !rx_sync_p1 && rx_prev_p2;
  assign hdr_n     = {rx_shift, n_words[7:0]};
  assign last_word = ({1'b0, word_idx} + 17'd1) == {1'b0, n_words};
  assign ld_active = (ld_state != DONE) && (ld_state != ERR);

  // Stages p0/p1: metastability synchronizer; p2 holds the previous sample for edge detect
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev_p2 <= 1'b1;
    end else begin
      rx_sync_p0 <= i_uart_rx;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev_p2 <= rx_sync_p1;
    end
  end

  // Stage p3: bit-timing FSM; byte/frame-error pulses land the cycle after the stop sample
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_state     <= RX_IDLE;
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      byte_vld_p3  <= 1'b0;
      frame_err_p3 <= 1'b0;
    end else begin
      byte_vld_p3  <= 1'b0;
      frame_err_p3 <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (start_det) begin
            rx_state <= RX_START;
            clk_cnt  <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            rx_state <= rx_sync_p1 ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt      <= '0;
            rx_state     <= RX_IDLE;
            byte_vld_p3  <= rx_sync_p1;
            frame_err_p3 <= !rx_sync_p1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // rx_shift stays stable from the stop sample until the next frame's first data bit
  always_ff @(posedge i_clk) begin
    if (rx_state == RX_DATA && clk_cnt == BIT_LAST)
      rx_shift <= {rx_sync_p1, rx_shift[7:1]};
  end

  always_ff @(posedge i_clk) begin
    if (ld_state == LOAD && byte_vld_p3 && byte_cnt != 3'd7)
      word_buf[{byte_cnt, 3'b000} +: 8] <= rx_shift;
  end

`ifdef NNRV_LOADER_CKSUM_EN
  logic [7:0] cksum;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      cksum <= '0;
    else if (byte_vld_p3 && (ld_state == HDR0 || ld_state == HDR1 || ld_state == LOAD))
      cksum <= cksum ^ rx_shift;
  end
`endif

  // Stage p4: image FSM and RAM write port
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ld_state      <= HDR0;
      n_words       <= '0;
      word_idx      <= '0;
      byte_cnt      <= '0;
      o_ram_wr_en   <= 1'b0;
      o_ram_wr_mask <= '0;
      o_ram_wr_addr <= '0;
      o_ram_wr_data <= '0;
      o_core_rst    <= 1'b1;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_ram_wr_en   <= 1'b0;
      o_ram_wr_mask <= '0;
      if (start_det && ld_active) o_busy <= 1'b1;
      if (frame_err_p3 && ld_active) begin
        ld_state <= ERR;
        o_err    <= 1'b1;
        o_busy   <= 1'b0;
      end else begin
        case (ld_state)
          HDR0: begin
            if (byte_vld_p3) begin
              n_words[7:0] <= rx_shift;
              ld_state     <= HDR1;
            end
          end
          HDR1: begin
            if (byte_vld_p3) begin
              n_words[15:8] <= rx_shift;
              word_idx      <= '0;
              byte_cnt      <= '0;
              if (hdr_n == 16'd0) begin
                ld_state   <= DONE;
                o_done     <= 1'b1;
                o_busy     <= 1'b0;
                o_core_rst <= 1'b0;
              end else if (hdr_n > MAX_N) begin
                ld_state <= ERR;
                o_err    <= 1'b1;
                o_busy   <= 1'b0;
              end else begin
                ld_state <= LOAD;
              end
            end
          end
          LOAD: begin
            if (o_ram_wr_en) begin
              word_idx <= word_idx + 16'd1;
              byte_cnt <= '0;
              if (last_word) begin
`ifdef NNRV_LOADER_CKSUM_EN
                ld_state <= CKSUM;
`else
                ld_state   <= DONE;
                o_done     <= 1'b1;
                o_busy     <= 1'b0;
                o_core_rst <= 1'b0;
`endif
              end
            end else if (byte_vld_p3) begin
              byte_cnt <= byte_cnt + 3'd1;
              if (byte_cnt == 3'd7) begin
                o_ram_wr_en   <= 1'b1;
                o_ram_wr_mask <= '1;
                o_ram_wr_addr <= {{(XLEN-19){1'b0}}, word_idx, 3'b000};
                o_ram_wr_data <= {rx_shift, word_buf};
              end
            end
          end
`ifdef NNRV_LOADER_CKSUM_EN
          CKSUM: begin
            if (byte_vld_p3) begin
              o_busy <= 1'b0;
              if (rx_shift == cksum) begin
                ld_state   <= DONE;
                o_done     <= 1'b1;
                o_core_rst <= 1'b0;
              end else begin
                ld_state <= ERR;
                o_err    <= 1'b1;
              end
            end
          end
`endif
          DONE, ERR: ;
          default: begin
            ld_state <= ERR;
            o_err    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nnrv_uart_loader.sv
// Bench for nnrv_uart_loader: serial images driven bit by bit, writes captured and
// compared against an image-level reference model.
module tb_nnrv_uart_loader;

  localparam int CPB  = 4;
  localparam int MAXW = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [63:0] wr_addr;
  logic        wr_en;
  logic [7:0]  wr_mask;
  logic [63:0] wr_data;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  nnrv_uart_loader #(
    .XLEN(64), .MASK_WIDTH(8), .CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx),
    .o_ram_wr_addr(wr_addr), .o_ram_wr_en(wr_en), .o_ram_wr_mask(wr_mask),
    .o_ram_wr_data(wr_data), .o_core_rst(core_rst), .o_busy(busy),
    .o_done(done), .o_err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Write capture, cleared whenever the DUT is held in reset
  logic [63:0] cap_addr[$];
  logic [63:0] cap_data[$];
  int   mask_bad = 0;
  int   cyc = 0;
  int   last_wr_cyc = 0;
  int   fall_cyc = 0;
  logic prev_core_rst = 1'b1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      cap_addr.delete();
      cap_data.delete();
      mask_bad      <= 0;
      last_wr_cyc   <= 0;
      fall_cyc      <= 0;
      prev_core_rst <= 1'b1;
    end else begin
      prev_core_rst <= core_rst;
      if (wr_en) begin
        cap_addr.push_back(wr_addr);
        cap_data.push_back(wr_data);
        last_wr_cyc <= cyc;
        if (wr_mask != 8'hFF) mask_bad <= mask_bad + 1;
      end else if (wr_mask != 8'h00) begin
        mask_bad <= mask_bad + 1;
      end
      if (prev_core_rst && !core_rst) fall_cyc <= cyc;
    end
  end

  logic [63:0] exp_data[$];
  bit          exp_err;
  bit          exp_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] q_at(input logic [63:0] q[$], input int k);
    if (k < q.size()) return q[k];
    return 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  function automatic logic [7:0] xsum(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  // Image-level reference: header count, little-endian words, optional XOR trailer
  task automatic model(input logic [7:0] img[$]);
    int n;
    logic [63:0] w;
    exp_data.delete();
    exp_err  = 1'b0;
    exp_done = 1'b0;
    if (img.size() < 2) return;
    n = int'(img[0]) + 256 * int'(img[1]);
    if (n > MAXW) begin
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (img.size() < 2 + 8 * (k + 1)) return;
      w = '0;
      for (int j = 0; j < 8; j++) w[8*j +: 8] = img[2 + 8*k + j];
      exp_data.push_back(w);
    end
`ifdef NNRV_LOADER_CKSUM_EN
    begin
      logic [7:0] x = 8'h00;
      if (img.size() < 3 + 8 * n) return;
      for (int i = 0; i < 2 + 8 * n; i++) x ^= img[i];
      if (img[2 + 8*n] == x) exp_done = 1'b1;
      else exp_err = 1'b1;
    end
`else
    exp_done = 1'b1;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic glitch();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic reset_dut();
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_result(input string tag);
    chk({tag, ":wr_count"}, 64'(cap_data.size()), 64'(exp_data.size()));
    foreach (exp_data[k]) begin
      chk({tag, ":addr"}, q_at(cap_addr, k), 64'(8 * k));
      chk({tag, ":data"}, q_at(cap_data, k), exp_data[k]);
    end
    chk({tag, ":done"}, 64'(done), 64'(exp_done));
    chk({tag, ":err"}, 64'(err), 64'(exp_err));
    chk({tag, ":core_rst"}, 64'(core_rst), 64'(!exp_done));
    chk({tag, ":busy"}, 64'(busy), 64'(0));
    chk({tag, ":mask"}, 64'(mask_bad), 64'(0));
`ifndef NNRV_LOADER_CKSUM_EN
    if (exp_done && exp_data.size() > 0)
      chk({tag, ":rst_gap"}, 64'(fall_cyc - last_wr_cyc), 64'(1));
`endif
  endtask

  task automatic run_image(input string tag, input logic [7:0] img[$], input int glitch_at);
    reset_dut();
    model(img);
    foreach (img[i]) begin
      if (i == glitch_at) glitch();
      send_byte(img[i], 1'b0);
    end
    chk({tag, ":rst_fast"}, 64'(core_rst), 64'(!exp_done));
    repeat (20) @(negedge clk);
    check_result(tag);
  endtask

  initial begin
    logic [7:0] img[$];
    int n;

    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst:wr_en", 64'(wr_en), 64'(0));
    chk("rst:mask", 64'(wr_mask), 64'(0));
    chk("rst:addr", wr_addr, 64'(0));
    chk("rst:data", wr_data, 64'(0));
    chk("rst:core_rst", 64'(core_rst), 64'(1));
    chk("rst:busy", 64'(busy), 64'(0));
    chk("rst:done", 64'(done), 64'(0));
    chk("rst:err", 64'(err), 64'(0));

    // Two-word directed image
    img = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
           8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`ifdef NNRV_LOADER_CKSUM_EN
    img.push_back(xsum(img));
`endif
    run_image("two_word", img, -1);
    chk("two_word:w0", q_at(cap_data, 0), 64'h8877665544332211);
    chk("two_word:w1", q_at(cap_data, 1), 64'h0807060504030201);
    chk("two_word:a1", q_at(cap_addr, 1), 64'h8);

    // Random images, the last with a one-cycle glitch between bytes
    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(1, 3);
      img = {8'(n), 8'h00};
      for (int i = 0; i < 8 * n; i++) img.push_back(8'($urandom));
`ifdef NNRV_LOADER_CKSUM_EN
      img.push_back(xsum(img));
`endif
      run_image("rand_img", img, (t == 2) ? int'($urandom_range(1, img.size() - 1)) : -1);
    end

    // Empty image
    img = {8'h00, 8'h00};
`ifdef NNRV_LOADER_CKSUM_EN
    img.push_back(xsum(img));
`endif
    run_image("empty", img, -1);

    // Oversize header
    img = {8'h81, 8'h00};
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    run_image("oversize", img, -1);

    // Framing error on the second byte, then a valid-looking image
    reset_dut();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
    repeat (20) @(negedge clk);
    chk("frame:wr_count", 64'(cap_data.size()), 64'(0));
    chk("frame:err", 64'(err), 64'(1));
    chk("frame:done", 64'(done), 64'(0));
    chk("frame:core_rst", 64'(core_rst), 64'(1));

    // Reset partway through a word, then a clean one-word image
    reset_dut();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    chk("midrst:busy", 64'(busy), 64'(1));
    chk("midrst:wr_count", 64'(cap_data.size()), 64'(0));
    img = {8'h01, 8'h00};
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
`ifdef NNRV_LOADER_CKSUM_EN
    img.push_back(xsum(img));
`endif
    run_image("midrst", img, -1);

`ifdef NNRV_LOADER_CKSUM_EN
    // Corrupted checksum trailer
    img = {8'h01, 8'h00};
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    img.push_back(xsum(img) ^ 8'h5A);
    run_image("bad_cksum", img, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nnrv_uart_loader.md
Name: nnrv_uart_loader

Overview:
- Boot loader upstream of the core: receives a program image over a UART line and writes it into the shared RAM as 64-bit words through the RAM write port.
- Holds the pipeline in reset until the image is complete.
- Releases core reset once loading finishes; RAM write port then idle (tie-off/mux with mem stage done at top level).

Parameters:
- XLEN, 64, RAM data width; image word size.
- MASK_WIDTH, 8, RAM byte-mask width (XLEN/8).
- CLKS_PER_BIT, 868, i_clk cycles per UART bit (8N1); minimum 4.
- MAX_WORDS, 128, largest accepted word count; larger headers rejected.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_uart_rx  in  1  asynchronous UART line, idle high
- o_ram_wr_addr  out  XLEN  byte address of word being written (word_index*8)
- o_ram_wr_en  out  1  one-cycle write strobe
- o_ram_wr_mask  out  MASK_WIDTH  always all-ones when o_ram_wr_en=1, else 0
- o_ram_wr_data  out  XLEN  assembled little-endian word
- o_core_rst  out  1  reset to the pipeline stages; high while loading
- o_busy  out  1  header or payload reception in progress
- o_done  out  1  image loaded, sticky until i_rst
- o_err  out  1  sticky error (framing, oversize, checksum)

Behaviour:
- Clock/reset: single clock i_clk; i_rst synchronous active-high, sampled on rising edge only.
- Reset values: o_ram_wr_en=0, o_ram_wr_mask=0, o_ram_wr_addr=0, o_ram_wr_data=0, o_core_rst=1, o_busy=0, o_done=0, o_err=0; all counters 0; FSM=HDR0.
- Reset mid-load: partial word discarded, no write issued, FSM back to HDR0.
- RX front end:
  - 2-FF synchronizer on i_uart_rx, initialised to 1.
  - Start detected on synchronized falling edge; re-sampled at CLKS_PER_BIT/2. If high, false start: return to idle, no byte.
  - Data bits sampled every CLKS_PER_BIT, LSB first.
  - Stop bit sampled once. If low: framing error, byte dropped, o_err=1, FSM->ERR.
  - A valid byte produces an internal 1-cycle byte_valid on the cycle after the stop-bit sample.
- Image format: byte0/byte1 = word count N (16-bit little-endian), then N*8 payload bytes, little-endian per word.
- FSM states and transitions:
  - HDR0: on byte, store N[7:0] -> HDR1. o_busy goes high on the first start bit.
  - HDR1: on byte, store N[15:8].
    - N=0: -> DONE next cycle.
    - N>MAX_WORDS: o_err=1 -> ERR.
    - Otherwise -> LOAD.
  - LOAD: each byte shifted into byte lane byte_cnt (0..7).
    - On the 8th byte, next cycle: o_ram_wr_en=1 for exactly one cycle, addr=word_idx*8, data=assembled word. Then word_idx++ and byte_cnt=0.
    - After the write of word N-1, -> DONE (or CKSUM if the optional feature is enabled).
  - DONE: o_done=1, o_busy=0. o_core_rst drops to 0 on the cycle after the last write, exactly 2 cycles after the last stop-bit sample. Further RX bytes are ignored.
  - ERR: o_core_rst stays 1, o_busy=0, no further writes; exit only via i_rst.
- Widths: word_idx 16 bits; address = {word_idx,3'b000} zero-extended to XLEN.
- Invariant: no two writes occur within CLKS_PER_BIT*10 cycles of each other.

Optional Feature:
- Macro NNRV_LOADER_CKSUM_EN.
- Defined:
  - One extra byte follows the payload: XOR of all header and payload bytes.
  - LOAD -> CKSUM after the last write. On that byte, if it matches: -> DONE, core released 1 cycle later. If it mismatches: o_err=1 -> ERR, core held in reset.
  - RAM contents already written are not cleared.
- Not defined: no checksum byte, no CKSUM state, no checksum logic synthesised; LOAD -> DONE directly.

Test Plan:
- CLKS_PER_BIT=4; send 02 00 then 8 bytes 11..88 then 8 bytes 01..08 -> write@0 data 0x8877665544332211, write@8 data 0x0807060504030201, mask 0xFF; o_done=1; o_core_rst falls 2 cycles after last stop sample.
- Header 00 00 -> no writes, o_done=1, o_core_rst=0 within 2 cycles of header stop bit.
- Header 81 00 with MAX_WORDS=128 -> o_err=1, no writes, o_core_rst stays 1.
- Second byte sent with stop bit forced 0 -> o_err=1, FSM ERR, later valid bytes cause no writes.
- 1-cycle low glitch on i_uart_rx between bytes -> treated as false start, no byte, load completes normally.
- Assert i_rst after 5 payload bytes, then resend full 1-word image -> single write@0 with correct data. With NNRV_LOADER_CKSUM_EN, a bad checksum byte gives o_err=1, o_done=0, o_core_rst=1.
